// File: rtl/tag_uart_framer_pkg.sv
// Shared types and helpers for the RFID tag-to-UART framer.
// Holds the FSM state encoding, the ASCII constants and hex-digit conversion.
package tag_uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] r;
    if (nib < 4'd10) begin
      r = {4'h3, nib};
    end else begin
      r = 8'h37 + {4'h0, nib};
    end
    return r;
  endfunction

endpackage

// File: rtl/tag_uart_framer_if.sv
// Byte handshake between the framer and the 8N1 UART transmitter.
// Signal names follow the framer's point of view.
interface tag_uart_framer_if;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;

  modport master (output o_Tx_DV, output o_Tx_Byte, input i_Tx_Active, input i_Tx_Done);
  modport slave  (input o_Tx_DV, input o_Tx_Byte, output i_Tx_Active, output i_Tx_Done);
endinterface

// File: rtl/tag_uart_framer_mux.sv
// Combinational frame-byte selector: header, hex ID (MSB nibble first),
// optional hex checksum, then CR LF.
module tag_frame_mux
  import tag_uart_pkg::*;
#(
  parameter int         ID_BYTES      = 5,
  parameter int         SEND_CHECKSUM = 1,
  parameter logic [7:0] HEADER_CHAR   = 8'h24,
  parameter int         IDX_W         = 4
) (
  input  logic [8*ID_BYTES-1:0] id_i,
  input  logic [7:0]            csum_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [7:0]            byte_o
);

  localparam int NIB_LAST = 2 * ID_BYTES;
  localparam int CS_HI    = NIB_LAST + 1;
  localparam int CR_POS   = NIB_LAST + 1 + 2 * SEND_CHECKSUM;

  logic [31:0]            idx_s;
  logic [8*ID_BYTES-1:0]  shifted_s;

  // Index k in 1..NIB_LAST picks the k-th nibble counted from the MSB end.
  always_comb begin
    idx_s     = 32'(idx_i);
    shifted_s = id_i >> (32'd4 * (NIB_LAST - idx_s));
    if (idx_s == 32'd0) begin
      byte_o = HEADER_CHAR;
    end else if (idx_s <= NIB_LAST) begin
      byte_o = nibble_to_ascii(shifted_s[3:0]);
    end else if ((SEND_CHECKSUM != 0) && (idx_s == CS_HI)) begin
      byte_o = nibble_to_ascii(csum_i[7:4]);
    end else if ((SEND_CHECKSUM != 0) && (idx_s == CS_HI + 1)) begin
      byte_o = nibble_to_ascii(csum_i[3:0]);
    end else if (idx_s == CR_POS) begin
      byte_o = ASCII_CR;
    end else if (idx_s == CR_POS + 1) begin
      byte_o = ASCII_LF;
    end else begin
      byte_o = 8'h00;
    end
  end

endmodule

// File: rtl/tag_uart_framer.sv
// Serialises a captured RFID tag ID into an ASCII frame for the UART
// transmitter, with a one-deep pending slot for tags arriving mid-frame.
module tag_uart_framer
  import tag_uart_pkg::*;
#(
  parameter int         ID_BYTES      = 5,
  parameter logic [7:0] HEADER_CHAR   = 8'h24,
  parameter int         SEND_CHECKSUM = 1
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Tag_Valid,
  input  logic [8*ID_BYTES-1:0] i_Tag_Id,
  tag_uart_framer_if.master     tx,
  output logic                  o_Busy,
  output logic                  o_Overrun
);

  localparam int FRAME_LEN = 1 + 2 * ID_BYTES + 2 * SEND_CHECKSUM + 2;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  function automatic logic [7:0] id_xor(input logic [8*ID_BYTES-1:0] id);
    logic [7:0] acc;
    acc = 8'h00;
    for (int b = 0; b < ID_BYTES; b++) begin
      acc = acc ^ id[8*b +: 8];
    end
    return acc;
  endfunction

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [8*ID_BYTES-1:0] id_q, id_d;
  logic [7:0]            csum_q, csum_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [8*ID_BYTES-1:0] pend_id_q, pend_id_d;
  logic                  dv_q, dv_d;
  logic [7:0]            byte_q, byte_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            mux_byte_s;

  tag_frame_mux #(
    .ID_BYTES      (ID_BYTES),
    .SEND_CHECKSUM (SEND_CHECKSUM),
    .HEADER_CHAR   (HEADER_CHAR),
    .IDX_W         (IDX_W)
  ) u_mux (
    .id_i   (id_q),
    .csum_i (csum_q),
    .idx_i  (idx_q),
    .byte_o (mux_byte_s)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      idx_q        <= {IDX_W{1'b0}};
      id_q         <= {(8*ID_BYTES){1'b0}};
      csum_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_id_q    <= {(8*ID_BYTES){1'b0}};
      dv_q         <= 1'b0;
      byte_q       <= 8'h00;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      csum_q       <= csum_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      dv_q         <= dv_d;
      byte_q       <= byte_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    id_d         = id_q;
    csum_d       = csum_q;
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    dv_d         = 1'b0;
    byte_d       = byte_q;
    busy_d       = busy_q;
    overrun_d    = 1'b0;

    // Mid-frame tags land in the slot; newest wins and overwriting flags overrun.
    if (i_Tag_Valid && ((state_q == ARM) || (state_q == WAIT))) begin
      pend_id_d    = i_Tag_Id;
      pend_valid_d = 1'b1;
      overrun_d    = pend_valid_q;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (i_Tag_Valid) begin
          id_d    = i_Tag_Id;
          csum_d  = id_xor(i_Tag_Id);
          idx_d   = {IDX_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ARM;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ARM: begin
        if (!tx.i_Tx_Active && !tx.i_Tx_Done) begin
          byte_d  = mux_byte_s;
          dv_d    = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = ARM;
        end
      end
      WAIT: begin
        if (tx.i_Tx_Done && (idx_q == LAST_IDX)) begin
          state_d = DONE;
        end else if (tx.i_Tx_Done) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ARM;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        // A tag in this cycle never overruns: it refills the slot or starts directly.
        if (pend_valid_q) begin
          id_d         = pend_id_q;
          csum_d       = id_xor(pend_id_q);
          idx_d        = {IDX_W{1'b0}};
          state_d      = ARM;
          if (i_Tag_Valid) begin
            pend_id_d    = i_Tag_Id;
            pend_valid_d = 1'b1;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (i_Tag_Valid) begin
          id_d    = i_Tag_Id;
          csum_d  = id_xor(i_Tag_Id);
          idx_d   = {IDX_W{1'b0}};
          state_d = ARM;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx.o_Tx_DV   = dv_q;
  assign tx.o_Tx_Byte = byte_q;
  assign o_Busy       = busy_q;
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_tag_uart_framer.sv
// Scoreboard bench for tag_uart_framer: expected frame bytes are queued at
// stimulus time and popped by per-DUT monitors on every o_Tx_DV.
module tb_tag_uart_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tag1_valid = 1'b0, tag0_valid = 1'b0;
  logic [39:0] tag1_id = 40'd0, tag0_id = 40'd0;
  logic        busy1, ovr1, busy0, ovr0;
  logic        act1 = 1'b0, done1 = 1'b0, hold1 = 1'b0, spur1 = 1'b0;
  logic        act0 = 1'b0, done0 = 1'b0;
  logic        hold_ok1 = 1'b0;
  logic [7:0]  held1;
  logic [7:0]  q1[$];
  logic [7:0]  q0[$];
  int          n_checks = 0, n_fail = 0;
  int          dv_cnt1 = 0, dv_cnt0 = 0, done_cnt1 = 0, falls1 = 0, ovr_cnt1 = 0;
  logic        busy1_prev = 1'b0;

  tag_uart_framer_if if1();
  tag_uart_framer_if if0();

  assign if1.i_Tx_Active = act1 | hold1;
  assign if1.i_Tx_Done   = done1 | spur1;
  assign if0.i_Tx_Active = act0;
  assign if0.i_Tx_Done   = done0;

  tag_uart_framer dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tag_Valid(tag1_valid), .i_Tag_Id(tag1_id),
    .tx(if1), .o_Busy(busy1), .o_Overrun(ovr1)
  );

  tag_uart_framer #(.SEND_CHECKSUM(0)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Tag_Valid(tag0_valid), .i_Tag_Id(tag0_id),
    .tx(if0), .o_Busy(busy0), .o_Overrun(ovr0)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent frame builder used for the non-hand-listed IDs.
  function automatic void push_frame(input bit to1, input logic [39:0] id, input int nbytes);
    string      hx;
    logic [7:0] f[$];
    logic [7:0] x;
    hx = "0123456789ABCDEF";
    x  = 8'h00;
    f.push_back(8'h24);
    for (int i = 9; i >= 0; i--) f.push_back(hx[id[4*i +: 4]]);
    for (int b = 0; b < 5; b++) x = x ^ id[8*b +: 8];
    if (to1) begin
      f.push_back(hx[x[7:4]]);
      f.push_back(hx[x[3:0]]);
    end
    f.push_back(8'h0D);
    f.push_back(8'h0A);
    for (int i = 0; i < nbytes && i < f.size(); i++) begin
      if (to1) q1.push_back(f[i]);
      else     q0.push_back(f[i]);
    end
  endfunction

  task automatic strobe1(input logic [39:0] id);
    @(negedge clk); tag1_valid = 1'b1; tag1_id = id;
    @(negedge clk); tag1_valid = 1'b0;
  endtask

  task automatic strobe0(input logic [39:0] id);
    @(negedge clk); tag0_valid = 1'b1; tag0_id = id;
    @(negedge clk); tag0_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit which1, input string nm);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 4000 && b; i++) begin
      @(negedge clk);
      b = which1 ? busy1 : busy0;
    end
    check(nm, {63'd0, b}, 64'd0);
  endtask

  task automatic wait_last_done1(input int target, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk);
      if (done1 && done_cnt1 == target) hit = 1'b1;
    end
    check(nm, {63'd0, hit}, 64'd1);
  endtask

  // Behavioural transmitter for dut1: busy for a few cycles, then a Done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (if1.o_Tx_DV) begin
        act1 = 1'b1; held1 = if1.o_Tx_Byte; hold_ok1 = 1'b1;
        repeat (3) @(negedge clk);
        if (hold_ok1) check("byte_hold", {56'd0, if1.o_Tx_Byte}, {56'd0, held1});
        act1 = 1'b0; done1 = 1'b1; done_cnt1++;
        @(negedge clk); done1 = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (if0.o_Tx_DV) begin
        act0 = 1'b1;
        repeat (3) @(negedge clk);
        act0 = 1'b0; done0 = 1'b1;
        @(negedge clk); done0 = 1'b0;
      end
    end
  end

  // Monitors: pop and compare on every DV; also track busy falls and overruns.
  initial begin
    forever begin
      @(negedge clk);
      if (busy1_prev && busy1 === 1'b0) falls1++;
      busy1_prev = busy1;
      if (ovr1 === 1'b1) ovr_cnt1++;
      if (if1.o_Tx_DV === 1'b1) begin
        dv_cnt1++;
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut1_unexpected_dv: got %0h expected no byte", if1.o_Tx_Byte);
        end else begin
          check($sformatf("dut1_byte%0d", dv_cnt1), {56'd0, if1.o_Tx_Byte}, {56'd0, q1.pop_front()});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (if0.o_Tx_DV === 1'b1) begin
        dv_cnt0++;
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dut0_unexpected_dv: got %0h expected no byte", if0.o_Tx_Byte);
        end else begin
          check($sformatf("dut0_byte%0d", dv_cnt0), {56'd0, if0.o_Tx_Byte}, {56'd0, q0.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp1 [15];
    logic [7:0] exp0 [13];
    int base, f0, o0;
    exp1 = '{8'h24, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43,
             8'h44, 8'h45, 8'h46, 8'h41, 8'h46, 8'h0D, 8'h0A};
    exp0 = '{8'h24, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
             8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};

    repeat (3) @(negedge clk);
    check("rst_dv",   {63'd0, if1.o_Tx_DV}, 64'd0);
    check("rst_byte", {56'd0, if1.o_Tx_Byte}, 64'd0);
    check("rst_busy", {63'd0, busy1}, 64'd0);
    check("rst_ovr",  {63'd0, ovr1}, 64'd0);
    rst = 1'b0;

    // Default frame with checksum AF, plus first-DV latency.
    for (int i = 0; i < 15; i++) q1.push_back(exp1[i]);
    strobe1(40'h1234ABCDEF);
    check("lat_busy", {63'd0, busy1}, 64'd1);
    check("lat_dv_n1", {63'd0, if1.o_Tx_DV}, 64'd0);
    @(negedge clk);
    check("lat_dv_n2", {63'd0, if1.o_Tx_DV}, 64'd1);
    @(negedge clk);
    check("lat_dv_n3", {63'd0, if1.o_Tx_DV}, 64'd0);
    wait_last_done1(15, "t1_last_done");
    @(negedge clk);
    check("t1_busy_in_done", {63'd0, busy1}, 64'd1);
    @(negedge clk);
    check("t1_busy_fall", {63'd0, busy1}, 64'd0);
    check("t1_q_empty", 64'(q1.size()), 64'd0);

    // No-checksum variant.
    for (int i = 0; i < 13; i++) q0.push_back(exp0[i]);
    strobe0(40'h0000000009);
    wait_idle(1'b0, "t2_idle");
    check("t2_q_empty", 64'(q0.size()), 64'd0);
    check("t2_dv_count", 64'(dv_cnt0), 64'd13);

    // A, B, C during frame A: overrun on C only, B dropped, C back-to-back.
    f0 = falls1; o0 = ovr_cnt1;
    push_frame(1'b1, 40'hA5A5A5A5A5, 15);
    strobe1(40'hA5A5A5A5A5);
    repeat (8) @(negedge clk);
    strobe1(40'hBBBBBBBBBB);
    check("t3_ovr_on_b", {63'd0, ovr1}, 64'd0);
    push_frame(1'b1, 40'hC0FFEE0042, 15);
    strobe1(40'hC0FFEE0042);
    check("t3_ovr_on_c", {63'd0, ovr1}, 64'd1);
    wait_idle(1'b1, "t3_idle");
    check("t3_ovr_count", 64'(ovr_cnt1 - o0), 64'd1);
    check("t3_busy_falls", 64'(falls1 - f0), 64'd1);
    check("t3_q_empty", 64'(q1.size()), 64'd0);

    // Tag in the DONE cycle with the slot full: three frames, no overrun.
    f0 = falls1; o0 = ovr_cnt1; base = done_cnt1;
    push_frame(1'b1, 40'h0102030405, 15);
    push_frame(1'b1, 40'hFEDCBA9876, 15);
    push_frame(1'b1, 40'h00000000FF, 15);
    strobe1(40'h0102030405);
    strobe1(40'hFEDCBA9876);
    wait_last_done1(base + 15, "t4_last_done_x");
    strobe1(40'h00000000FF);
    check("t4_ovr_done", {63'd0, ovr1}, 64'd0);
    wait_idle(1'b1, "t4_idle");
    check("t4_ovr_count", 64'(ovr_cnt1 - o0), 64'd0);
    check("t4_busy_falls", 64'(falls1 - f0), 64'd1);
    check("t4_q_empty", 64'(q1.size()), 64'd0);

    // Reset during byte 6 with a pending tag; then spurious Dones in IDLE and ARM.
    base = dv_cnt1;
    push_frame(1'b1, 40'h1122334455, 6);
    strobe1(40'h1122334455);
    repeat (4) @(negedge clk);
    strobe1(40'h9999999999);
    for (int i = 0; i < 2000 && dv_cnt1 < base + 6; i++) @(negedge clk);
    check("t5_reached_byte6", 64'(dv_cnt1 - base), 64'd6);
    hold_ok1 = 1'b0; hold1 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_dv",   {63'd0, if1.o_Tx_DV}, 64'd0);
    check("t5_rst_byte", {56'd0, if1.o_Tx_Byte}, 64'd0);
    check("t5_rst_busy", {63'd0, busy1}, 64'd0);
    check("t5_rst_ovr",  {63'd0, ovr1}, 64'd0);
    check("t5_q_empty_at_rst", 64'(q1.size()), 64'd0);
    base = dv_cnt1;
    spur1 = 1'b1; @(negedge clk); spur1 = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_spur_idle_dv", 64'(dv_cnt1 - base), 64'd0);
    check("t6_spur_idle_busy", {63'd0, busy1}, 64'd0);
    push_frame(1'b1, 40'h5A5A00FF11, 15);
    strobe1(40'h5A5A00FF11);
    repeat (3) @(negedge clk);
    spur1 = 1'b1; @(negedge clk); spur1 = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_held_in_arm_dv", 64'(dv_cnt1 - base), 64'd0);
    check("t6_held_busy", {63'd0, busy1}, 64'd1);
    hold1 = 1'b0;
    wait_idle(1'b1, "t5_idle");
    check("t5_frame_len", 64'(dv_cnt1 - base), 64'd15);
    check("t5_q_empty", 64'(q1.size()), 64'd0);

    repeat (10) @(negedge clk);
    check("end_q1_empty", 64'(q1.size()), 64'd0);
    check("end_q0_empty", 64'(q0.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_uart_framer.md
Name: tag_uart_framer

Overview:
Upstream feeder for the 8N1 UART transmitter. It accepts a decoded RFID tag ID as a one-cycle strobe and serialises it into an ASCII frame: header, uppercase hex ID (MSB nibble first), optional XOR checksum in hex, then CR LF. It hands the frame to the transmitter one byte at a time over its DV/Done handshake. A one-deep pending slot absorbs a tag that arrives mid-frame.

Parameters:
ID_BYTES, 5, tag ID width in bytes; i_Tag_Id is 8*ID_BYTES bits
HEADER_CHAR, 8'h24, first byte of every frame ('$')
SEND_CHECKSUM, 1, 1 = append XOR of raw ID bytes as 2 hex chars; 0 = omit

Ports:
i_Clock  in  1  system clock, single domain
i_Reset  in  1  synchronous, active-high reset
i_Tag_Valid  in  1  one-cycle strobe: i_Tag_Id valid
i_Tag_Id  in  8*ID_BYTES  tag ID, byte ID_BYTES-1 is sent first
i_Tx_Active  in  1  transmitter busy flag
i_Tx_Done  in  1  transmitter one-cycle completion pulse
o_Tx_DV  out  1  one-cycle strobe to transmitter: load o_Tx_Byte
o_Tx_Byte  out  8  byte to send, stable from the o_Tx_DV cycle until i_Tx_Done
o_Busy  out  1  high from tag capture until the last byte's i_Tx_Done
o_Overrun  out  1  one-cycle pulse when a pending tag is overwritten

Behaviour:
- Reset (synchronous, i_Reset high at a rising edge): o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Overrun=0, pending slot empty, state IDLE. Reset has priority over all other inputs.
- FRAME_LEN = 1 + 2*ID_BYTES + 2*SEND_CHECKSUM + 2. This is 15 at the defaults. The byte index counter is sized $clog2(FRAME_LEN).
- Nibble to ASCII: 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46 (uppercase only).
- Checksum: the XOR of the ID_BYTES raw ID bytes. It is computed at capture and held in a register.
- States:
  - IDLE: when i_Tag_Valid is high, capture the ID and checksum, set o_Busy=1, index=0, and go to ARM.
  - ARM: wait until i_Tx_Active=0 and i_Tx_Done=0. Then register o_Tx_Byte=byte[index], pulse o_Tx_DV for exactly one cycle, and go to WAIT.
  - WAIT: hold o_Tx_Byte.
    - On i_Tx_Done with index<FRAME_LEN-1: index+1, go to ARM.
    - On i_Tx_Done with index=FRAME_LEN-1: go to DONE.
  - DONE: if the pending slot is full, load it as the new frame (index=0, slot emptied) and go to ARM, keeping o_Busy=1. Otherwise o_Busy=0 and go to IDLE.
- Latency: i_Tag_Valid sampled at edge N in IDLE with the transmitter idle -> o_Tx_DV high after edge N+1, low after edge N+2.
- ARM always lasts at least one cycle after a Done. DV therefore never lands in the transmitter's post-stop cleanup cycle.
- Tag arrives while o_Busy=1:
  - Slot empty: stored in the pending slot.
  - Slot full: overwritten (newest wins) and o_Overrun pulses for one cycle.
  - The current frame is never altered.
- i_Tag_Valid in the same cycle DONE loads the pending tag: the pending tag is loaded and the new tag is stored in the slot. No overrun is flagged.
- i_Tag_Valid during the final byte's i_Tx_Done cycle is handled as "while busy".
- Reset mid-frame: the frame is abandoned and the pending slot cleared. The transmitter is not reset, so the first DV after reset still waits in ARM for i_Tx_Active=0.
- i_Tx_Done outside WAIT is ignored.

Decomposition:
- Package tag_uart_pkg holds:
  - a state enum: IDLE, ARM, WAIT, DONE
  - a function nibble_to_ascii (4 bits -> 8 bits)
  - constants ASCII_CR=8'h0D and ASCII_LF=8'h0A
- Sub-module tag_frame_mux: a combinational index-to-byte selector. It takes the ID, checksum and index and outputs the frame byte, keeping the FSM small.

Test Plan:
- Default parameters, ID 40'h1234ABCDEF, real transmitter with CLKS_PER_BIT=4 -> 15 DV bytes in order 24 31 32 33 34 41 42 43 44 45 46 41 46 0D 0A. The checksum is AF. The serial line decodes the same bytes. o_Busy falls one cycle after the last Done.
- SEND_CHECKSUM=0, ID 40'h0000000009 -> 13 bytes: 24 30 30 30 30 30 30 30 30 30 39 0D 0A. No checksum bytes.
- Tags A, B, C strobed during frame A -> o_Overrun pulses once, on C. Frame A completes unchanged, then frame C is sent back-to-back (o_Busy never drops). B is never sent.
- Tag strobed in the DONE cycle with the slot full -> pending frame starts, new tag held, no overrun. Three frames total.
- i_Reset asserted at byte 6 of a frame -> all outputs at reset values the next cycle, slot empty. A new tag is held in ARM until the transmitter drops i_Tx_Active, then a full frame starts from byte 0.
- Spurious i_Tx_Done pulse in IDLE and in ARM -> no DV, index unchanged.
